// File: rtl/pad_domain_sequencer.sv
// Pad supply domain sequencer: ordered, debounced power-up of N_DOM domains,
// reverse-order power-down, pgood timeout and brown-out fault handling.
module pad_domain_sequencer #(
  parameter int N_DOM = 4,
  parameter int CNT_W = 8,
  parameter int DEB   = 3
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic             stop,
  input  logic             clr_fault,
  input  logic [CNT_W-1:0] dly,
  input  logic [CNT_W-1:0] tmo,
  input  logic [N_DOM-1:0] pgood,
  output logic [N_DOM-1:0] en,
  output logic             ready,
  output logic             busy,
  output logic             fault,
  output logic [2:0]       fault_idx
);

  localparam int         DEB_W    = $clog2(DEB + 1);
  localparam logic [2:0] LAST_IDX = 3'(N_DOM - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UP_PG,
    S_UP_DLY,
    S_ON,
    S_DOWN,
    S_FAULT
  } state_t;

  state_t                      state_q, state_d;
  logic [2:0]                  idx_q, idx_d;
  logic [N_DOM-1:0]            en_q, en_d;
  logic [DEB_W-1:0]            pg_cnt_q, pg_cnt_d;
  logic [CNT_W-1:0]            tmo_cnt_q, tmo_cnt_d;
  logic [CNT_W-1:0]            dly_cnt_q, dly_cnt_d;
  logic [N_DOM-1:0][DEB_W-1:0] lo_cnt_q, lo_cnt_d;
  logic [2:0]                  fault_idx_q, fault_idx_d;

  logic             pg_cur;
  logic             pg_hit;
  logic             tmo_hit;
  logic             dly_done;
  logic             on_fault;
  logic [2:0]       low_idx;
  logic [N_DOM-1:0] idx_oh;
  logic [N_DOM-1:0] idx_up_oh;
  logic [N_DOM-1:0] idx_dn_oh;

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  function automatic logic [DEB_W-1:0] sat_deb(input logic [DEB_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      idx_q       <= 3'd0;
      en_q        <= '0;
      pg_cnt_q    <= '0;
      tmo_cnt_q   <= '0;
      dly_cnt_q   <= '0;
      lo_cnt_q    <= '0;
      fault_idx_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      en_q        <= en_d;
      pg_cnt_q    <= pg_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      dly_cnt_q   <= dly_cnt_d;
      lo_cnt_q    <= lo_cnt_d;
      fault_idx_q <= fault_idx_d;
    end
  end

  // Decoded domain selects and the qualified events the FSM reacts to.
  always_comb begin
    idx_oh    = '0;
    idx_up_oh = '0;
    idx_dn_oh = '0;
    for (int j = 0; j < N_DOM; j++) begin
      idx_oh[j]    = (3'(j) == idx_q);
      idx_up_oh[j] = (3'(j) == 3'(idx_q + 3'd1));
      idx_dn_oh[j] = (3'(j) == 3'(idx_q - 3'd1));
    end
    pg_cur   = |(pgood & idx_oh);
    pg_hit   = pg_cur && (int'(pg_cnt_q) + 1 >= DEB);
    tmo_hit  = (tmo != '0) && (int'(tmo_cnt_q) + 1 >= int'(tmo));
    dly_done = (dly_cnt_q == dly);
    on_fault = 1'b0;
    low_idx  = 3'd0;
    // Scanning downward leaves the lowest failing domain in low_idx.
    for (int j = N_DOM - 1; j >= 0; j--) begin
      if (!pgood[j] && (int'(lo_cnt_q[j]) + 1 >= DEB)) begin
        on_fault = 1'b1;
        low_idx  = 3'(j);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start && !stop) state_d = S_UP_PG;
      end
      S_UP_PG: begin
        if (tmo_hit && !pg_hit) state_d = S_FAULT;
        else if (stop)          state_d = S_DOWN;
        else if (pg_hit)        state_d = S_UP_DLY;
      end
      S_UP_DLY: begin
        if (stop)          state_d = S_DOWN;
        else if (dly_done) state_d = (idx_q == LAST_IDX) ? S_ON : S_UP_PG;
      end
      S_ON: begin
        if (on_fault)  state_d = S_FAULT;
        else if (stop) state_d = S_DOWN;
      end
      S_DOWN: begin
        if (dly_done && (idx_q == 3'd0)) state_d = S_IDLE;
      end
      S_FAULT: begin
        if (clr_fault) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Enables, domain index and counters follow the chosen transition.
  always_comb begin
    idx_d       = idx_q;
    en_d        = en_q;
    pg_cnt_d    = pg_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    dly_cnt_d   = dly_cnt_q;
    lo_cnt_d    = lo_cnt_q;
    fault_idx_d = fault_idx_q;
    case (state_q)
      S_IDLE: begin
        en_d  = '0;
        idx_d = 3'd0;
        if (state_d == S_UP_PG) begin
          en_d      = N_DOM'(1);
          pg_cnt_d  = '0;
          tmo_cnt_d = '0;
        end
      end
      S_UP_PG: begin
        if (state_d == S_FAULT) begin
          fault_idx_d = idx_q;
          en_d        = '0;
        end else if (state_d == S_DOWN) begin
          en_d      = en_q & ~idx_oh;
          dly_cnt_d = '0;
        end else if (state_d == S_UP_DLY) begin
          dly_cnt_d = '0;
        end else begin
          pg_cnt_d  = pg_cur ? sat_deb(pg_cnt_q) : '0;
          tmo_cnt_d = sat_cnt(tmo_cnt_q);
        end
      end
      S_UP_DLY: begin
        if (state_d == S_DOWN) begin
          en_d      = en_q & ~idx_oh;
          dly_cnt_d = '0;
        end else if (state_d == S_UP_PG) begin
          idx_d     = idx_q + 3'd1;
          en_d      = en_q | idx_up_oh;
          pg_cnt_d  = '0;
          tmo_cnt_d = '0;
        end else if (state_d == S_ON) begin
          lo_cnt_d = '0;
        end else begin
          dly_cnt_d = sat_cnt(dly_cnt_q);
        end
      end
      S_ON: begin
        if (state_d == S_FAULT) begin
          fault_idx_d = low_idx;
          en_d        = '0;
        end else if (state_d == S_DOWN) begin
          idx_d           = LAST_IDX;
          en_d[N_DOM-1]   = 1'b0;
          dly_cnt_d       = '0;
        end else begin
          for (int j = 0; j < N_DOM; j++) begin
            lo_cnt_d[j] = pgood[j] ? '0 : sat_deb(lo_cnt_q[j]);
          end
        end
      end
      S_DOWN: begin
        if (!dly_done) begin
          dly_cnt_d = sat_cnt(dly_cnt_q);
        end else if (state_d == S_DOWN) begin
          idx_d     = idx_q - 3'd1;
          en_d      = en_q & ~idx_dn_oh;
          dly_cnt_d = '0;
        end
      end
      S_FAULT: begin
        en_d = '0;
        if (clr_fault) begin
          fault_idx_d = 3'd0;
          idx_d       = 3'd0;
        end
      end
      default: begin
        en_d  = '0;
        idx_d = 3'd0;
      end
    endcase
  end

  always_comb begin
    en        = en_q;
    ready     = (state_q == S_ON);
    busy      = (state_q == S_UP_PG) || (state_q == S_UP_DLY) || (state_q == S_DOWN);
    fault     = (state_q == S_FAULT);
    fault_idx = fault_idx_q;
  end

endmodule

// File: tb/tb_pad_domain_sequencer.sv
// Bench for pad_domain_sequencer: directed scenarios then randomized traffic,
// every cycle compared against a phase-level reference model.
module tb_pad_domain_sequencer;

  localparam int N_DOM = 4;
  localparam int CNT_W = 8;
  localparam int DEB   = 3;

  logic             clock;
  logic             resetn;
  logic             start;
  logic             stop;
  logic             clr_fault;
  logic [CNT_W-1:0] dly;
  logic [CNT_W-1:0] tmo;
  logic [N_DOM-1:0] pgood;
  logic [N_DOM-1:0] mask;
  logic [N_DOM-1:0] en_o;
  logic             ready_o;
  logic             busy_o;
  logic             fault_o;
  logic [2:0]       fault_idx_o;

  int checks;
  int failures;
  int cyc;

  // Reference model: phase name, enables, index and run-length bookkeeping.
  string            ph;
  logic [N_DOM-1:0] m_en;
  int               m_idx;
  int               m_fidx;
  int               hi_run;
  int               elapsed;
  int               wait_left;
  int               low_run [N_DOM];

  pad_domain_sequencer #(.N_DOM(N_DOM), .CNT_W(CNT_W), .DEB(DEB)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .start     (start),
    .stop      (stop),
    .clr_fault (clr_fault),
    .dly       (dly),
    .tmo       (tmo),
    .pgood     (pgood),
    .en        (en_o),
    .ready     (ready_o),
    .busy      (busy_o),
    .fault     (fault_o),
    .fault_idx (fault_idx_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [N_DOM-1:0] oneHot(input int i);
    return N_DOM'(1) << i;
  endfunction

  function automatic logic bitAt(input logic [N_DOM-1:0] v, input int i);
    return |(v & oneHot(i));
  endfunction

  task automatic modelReset();
    ph        = "IDLE";
    m_en      = '0;
    m_idx     = 0;
    m_fidx    = 0;
    hi_run    = 0;
    elapsed   = 0;
    wait_left = 0;
    for (int j = 0; j < N_DOM; j++) low_run[j] = 0;
  endtask

  // Advances the model by one clock edge using the inputs currently applied.
  task automatic modelStep();
    if (!resetn) begin
      modelReset();
    end else if (ph == "IDLE") begin
      if (start && !stop) begin
        ph      = "UP_PG";
        m_idx   = 0;
        m_en    = oneHot(0);
        hi_run  = 0;
        elapsed = 0;
      end
    end else if (ph == "UP_PG") begin
      int   run;
      logic debounced;
      logic expired;
      run       = bitAt(pgood, m_idx) ? hi_run + 1 : 0;
      debounced = (run >= DEB);
      expired   = (tmo != 0) && (elapsed + 1 >= int'(tmo));
      if (expired && !debounced) begin
        ph     = "FAULT";
        m_fidx = m_idx;
        m_en   = '0;
      end else if (stop) begin
        ph        = "DOWN";
        m_en      = m_en & ~oneHot(m_idx);
        wait_left = dly + 1;
      end else if (debounced) begin
        ph        = "UP_DLY";
        wait_left = dly + 1;
      end else begin
        hi_run  = run;
        elapsed = elapsed + 1;
      end
    end else if (ph == "UP_DLY") begin
      wait_left = wait_left - 1;
      if (stop) begin
        ph        = "DOWN";
        m_en      = m_en & ~oneHot(m_idx);
        wait_left = dly + 1;
      end else if (wait_left == 0) begin
        if (m_idx == N_DOM - 1) begin
          ph = "ON";
          for (int j = 0; j < N_DOM; j++) low_run[j] = 0;
        end else begin
          m_idx   = m_idx + 1;
          m_en    = m_en | oneHot(m_idx);
          ph      = "UP_PG";
          hi_run  = 0;
          elapsed = 0;
        end
      end
    end else if (ph == "ON") begin
      int first_low;
      first_low = -1;
      for (int j = 0; j < N_DOM; j++) begin
        low_run[j] = bitAt(pgood, j) ? 0 : low_run[j] + 1;
        if (first_low < 0 && low_run[j] >= DEB) first_low = j;
      end
      if (first_low >= 0) begin
        ph     = "FAULT";
        m_fidx = first_low;
        m_en   = '0;
      end else if (stop) begin
        ph        = "DOWN";
        m_idx     = N_DOM - 1;
        m_en      = m_en & ~oneHot(N_DOM - 1);
        wait_left = dly + 1;
      end
    end else if (ph == "DOWN") begin
      wait_left = wait_left - 1;
      if (wait_left == 0) begin
        if (m_idx == 0) begin
          ph = "IDLE";
        end else begin
          m_idx     = m_idx - 1;
          m_en      = m_en & ~oneHot(m_idx);
          wait_left = dly + 1;
        end
      end
    end else if (ph == "FAULT") begin
      if (clr_fault) begin
        ph     = "IDLE";
        m_fidx = 0;
        m_idx  = 0;
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    logic exp_ready;
    logic exp_busy;
    logic exp_fault;
    exp_ready = (ph == "ON");
    exp_busy  = (ph == "UP_PG") || (ph == "UP_DLY") || (ph == "DOWN");
    exp_fault = (ph == "FAULT");
    checks++;
    assert (en_o === m_en) else begin
      failures++;
      $error("[TB] FAIL %s en cyc=%0d got=%b exp=%b", tag, cyc, en_o, m_en);
    end
    checks++;
    assert (ready_o === exp_ready) else begin
      failures++;
      $error("[TB] FAIL %s ready cyc=%0d got=%b exp=%b", tag, cyc, ready_o, exp_ready);
    end
    checks++;
    assert (busy_o === exp_busy) else begin
      failures++;
      $error("[TB] FAIL %s busy cyc=%0d got=%b exp=%b", tag, cyc, busy_o, exp_busy);
    end
    checks++;
    assert (fault_o === exp_fault) else begin
      failures++;
      $error("[TB] FAIL %s fault cyc=%0d got=%b exp=%b", tag, cyc, fault_o, exp_fault);
    end
    checks++;
    assert (fault_idx_o === 3'(m_fidx)) else begin
      failures++;
      $error("[TB] FAIL %s fault_idx cyc=%0d got=%0d exp=%0d", tag, cyc, fault_idx_o, m_fidx);
    end
  endtask

  task automatic checkValue(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("[TB] FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One clock cycle: pgood follows the enables minus the injected drop mask.
  task automatic applyStimulus(input string tag);
    pgood = en_o & ~mask;
    modelStep();
    @(posedge clock);
    #1;
    cyc++;
    checkOutput(tag);
  endtask

  task automatic runCycles(input string tag, input int n);
    for (int i = 0; i < n; i++) applyStimulus(tag);
  endtask

  initial begin
    int               t0;
    int               t1;
    logic [N_DOM-1:0] prev_en;
    logic [N_DOM-1:0] down_seq [4];
    down_seq  = '{4'b0111, 4'b0011, 4'b0001, 4'b0000};
    checks    = 0;
    failures  = 0;
    cyc       = 0;
    resetn    = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    clr_fault = 1'b0;
    dly       = 8'd3;
    tmo       = 8'd0;
    mask      = '0;
    pgood     = '0;
    modelReset();
    $display("[TB] reset and idle behaviour");
    runCycles("reset", 2);
    resetn = 1'b1;
    runCycles("idle_no_start", 5);

    start = 1'b1;
    stop  = 1'b1;
    applyStimulus("start_and_stop");
    start = 1'b0;
    stop  = 1'b0;
    runCycles("start_and_stop_after", 3);
    checkValue("start_and_stop_en", int'(en_o), 0);

    $display("[TB] power-up with dly=3");
    dly     = 8'd3;
    start   = 1'b1;
    t0      = -1;
    t1      = -1;
    prev_en = en_o;
    for (int c = 0; c < 40; c++) begin
      applyStimulus("powerup");
      start = 1'b0;
      if (!prev_en[0] && en_o[0]) t0 = c;
      if (!prev_en[1] && en_o[1]) t1 = c;
      prev_en = en_o;
    end
    checkValue("rise_spacing", t1 - t0, DEB + 3 + 1);
    checkValue("ready_after_powerup", int'(ready_o), 1);

    $display("[TB] brown-out debounce in ON");
    mask = 4'b0100;
    runCycles("glitch_short", DEB - 1);
    mask = '0;
    runCycles("glitch_gap", 3);
    checkValue("short_glitch_no_fault", int'(fault_o), 0);
    mask = 4'b0100;
    runCycles("glitch_long", DEB);
    checkValue("long_glitch_fault", int'(fault_o), 1);
    checkValue("long_glitch_idx", int'(fault_idx_o), 2);
    checkValue("long_glitch_en", int'(en_o), 0);
    mask  = '0;
    start = 1'b1;
    stop  = 1'b1;
    runCycles("fault_hold", 3);
    start     = 1'b0;
    stop      = 1'b0;
    clr_fault = 1'b1;
    applyStimulus("fault_clear");
    clr_fault = 1'b0;
    checkValue("clear_fault", int'(fault_o), 0);
    checkValue("clear_fault_idx", int'(fault_idx_o), 0);

    $display("[TB] power-down ordering with dly=2");
    dly   = 8'd2;
    start = 1'b1;
    applyStimulus("up_dly2");
    start = 1'b0;
    runCycles("up_dly2", 30);
    checkValue("ready_dly2", int'(ready_o), 1);
    stop = 1'b1;
    applyStimulus("stop_on");
    stop = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checkValue("down_step", int'(en_o), int'(down_seq[k]));
      runCycles("down", 3);
    end
    checkValue("down_idle_busy", int'(busy_o), 0);

    $display("[TB] pgood timeout");
    tmo   = 8'd5;
    dly   = 8'd1;
    mask  = 4'b0010;
    start = 1'b1;
    applyStimulus("tmo_start");
    start = 1'b0;
    runCycles("tmo_wait", 15);
    checkValue("tmo_fault", int'(fault_o), 1);
    checkValue("tmo_fault_idx", int'(fault_idx_o), 1);
    checkValue("tmo_en", int'(en_o), 0);
    mask      = '0;
    clr_fault = 1'b1;
    applyStimulus("tmo_clear");
    clr_fault = 1'b0;
    checkValue("tmo_cleared", int'(fault_o), 0);

    $display("[TB] timeout disabled");
    tmo   = 8'd0;
    mask  = 4'b0001;
    start = 1'b1;
    applyStimulus("notmo_start");
    start = 1'b0;
    runCycles("notmo_hold", 300);
    checkValue("notmo_busy", int'(busy_o), 1);
    checkValue("notmo_no_fault", int'(fault_o), 0);
    stop = 1'b1;
    applyStimulus("notmo_abort");
    stop = 1'b0;
    runCycles("notmo_down", 4);
    mask = '0;
    checkValue("notmo_idle", int'(busy_o), 0);

    $display("[TB] asynchronous reset during UP_DLY");
    dly   = 8'd6;
    start = 1'b1;
    applyStimulus("rst_start");
    start = 1'b0;
    runCycles("rst_reach_dly", DEB + 2);
    checkValue("rst_in_up_dly_busy", int'(busy_o), 1);
    resetn = 1'b0;
    #1;
    modelReset();
    checkOutput("async_reset");
    checkValue("async_reset_en", int'(en_o), 0);
    runCycles("reset_hold", 1);
    resetn = 1'b1;
    runCycles("post_reset_idle", 8);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      start     = ($urandom_range(0, 5) == 0);
      stop      = ($urandom_range(0, 39) == 0);
      clr_fault = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0)
        mask = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : '0;
      if (ph == "IDLE") begin
        dly = 8'($urandom_range(0, 4));
        tmo = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(4, 12));
      end
      applyStimulus("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pad_domain_sequencer.md
PAD_DOMAIN_SEQUENCER -- requirements
Module: pad_domain_sequencer

Interface
REQ-001 SHALL have parameter N_DOM, default 4, meaning number of sequenced pad supply domains (1..8).
REQ-002 SHALL have parameter CNT_W, default 8, meaning width of the delay and timeout counters.
REQ-003 SHALL have parameter DEB, default 3, meaning consecutive cycles a pgood level must hold to count as a debounced level (DEB>=1).
REQ-004 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, power-up request, sampled each cycle.
REQ-007 SHALL have port stop, input, 1, power-down request, sampled each cycle.
REQ-008 SHALL have port clr_fault, input, 1, fault clear.
REQ-009 SHALL have port dly, input, CNT_W, settle cycles between domain steps.
REQ-010 SHALL have port tmo, input, CNT_W, pgood timeout in cycles; 0 disables the timeout.
REQ-011 SHALL have port pgood, input, N_DOM, per-domain power-good, synchronous to clock.
REQ-012 SHALL have port en, output, N_DOM, registered per-domain enable (clamp release).
REQ-013 SHALL have port ready, output, 1, high only in state ON.
REQ-014 SHALL have port busy, output, 1, high in UP_PG, UP_DLY, DOWN.
REQ-015 SHALL have port fault, output, 1, high only in state FAULT.
REQ-016 SHALL have port fault_idx, output, 3, index of the faulting domain, held until cleared.

Function
REQ-017 SHALL implement states IDLE, UP_PG, UP_DLY, ON, DOWN, FAULT, with a domain index idx.
REQ-018 IDLE: en all 0; start=1 and stop=0 -> set en[0], idx=0, go UP_PG; start and stop together -> stay IDLE.
REQ-019 UP_PG: count consecutive cycles pgood[idx]=1 (a 0 restarts the count); DEB such cycles -> UP_DLY with dly counter 0.
REQ-020 UP_PG: tmo!=0 and tmo cycles elapsed in UP_PG without debounce -> FAULT, fault_idx=idx.
REQ-021 UP_DLY: when dly counter equals dly, if idx=N_DOM-1 go ON, else set en[idx+1], idx++, go UP_PG; otherwise increment counter; dly=0 gives one cycle in UP_DLY.
REQ-022 Timing: with pgood following en without delay, en[k+1] SHALL rise DEB+dly+1 cycles after en[k].
REQ-023 en SHALL be cumulative during power-up: en[j]=1 for all j<=idx.
REQ-024 ON: any domain with debounced pgood=0 -> FAULT, fault_idx=lowest such index; stop=1 -> DOWN with idx=N_DOM-1; fault takes priority over stop in the same cycle.
REQ-025 stop=1 in UP_PG or UP_DLY SHALL abort to DOWN at the current idx; start is ignored outside IDLE.
REQ-026 DOWN: clear en[idx], wait dly+1 cycles, then idx-- and repeat; after en[0] clears and its wait completes -> IDLE. Reverse order is mandatory.
REQ-027 FAULT: en SHALL be all 0 on the cycle after entry; remain in FAULT until clr_fault=1 -> IDLE; start/stop ignored.
REQ-028 Counters SHALL saturate, never wrap; the pgood check in DOWN is disabled.

Reset
REQ-029 resetn=0 SHALL asynchronously force state IDLE, idx=0, counters 0, en=0, ready=0, busy=0, fault=0, fault_idx=0.
REQ-030 Reset mid-sequence SHALL drop all en immediately (asynchronous), with no power-down ordering.
REQ-031 After reset release, no en SHALL rise without a new start.

Verification
REQ-032 N_DOM=2, DEB=2, dly=3, pgood=en: start pulse -> en=01 next edge, en=11 six cycles later, ready one cycle after UP_DLY completes for idx 1.
REQ-033 tmo=5, pgood[1] stuck 0 -> fault=1, fault_idx=1, en=00 on next cycle; clr_fault -> IDLE, fault=0.
REQ-034 In ON, pgood[2] low for DEB-1 cycles -> no fault; low for DEB cycles -> FAULT, fault_idx=2.
REQ-035 ON with stop, N_DOM=4, dly=2 -> en steps 1111, 0111, 0011, 0001, 0000 at 3-cycle intervals, then IDLE.
REQ-036 start and stop same cycle in IDLE -> no en change; resetn low during UP_DLY -> en=0 immediately, all outputs at reset values.
REQ-037 tmo=0, pgood[0] held 0 for 300 cycles -> remains UP_PG with busy=1 and no fault.
